// File: rtl/uart_rx_word_packer_pkg.sv
// Shared definitions for the UART receive path: byte/word widths and the
// packer state encoding used by the receiver, transmitter and loader.
package uart_rx_word_packer_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   // Packer state names the index of the next byte to be captured.
   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } pack_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy counter.
// A push while full is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             pop_ok_s;
   logic             push_ok_s;

   assign full      = (count_r == (PTR_W+1)'(DEPTH));
   assign empty     = (count_r == {(PTR_W+1){1'b0}});
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign pop_ok_s  = pop & ~empty;
   assign push_ok_s = push & (~full | pop_ok_s);

   // Storage array and pointers; pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Occupancy: up on push only, down on pop only, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes little-endian into 32-bit words, queues them in a
// small FIFO and hands them out over valid/ready with a sticky overrun flag.
module uart_rx_word_packer
   import uart_rx_word_packer_pkg::*;
#(
   parameter int BYTES_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int PTR_W          = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_done_tick,
   input  logic [BYTE_W-1:0] din,
   input  logic              flush,
   input  logic              word_ready,
   input  logic              overrun_clr,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [PTR_W:0]    count,
   output logic              overrun
);

   // Only the first three bytes need holding; the last one goes straight in.
   localparam int SHIFT_W = (BYTES_PER_WORD - 1) * BYTE_W;

   pack_state_e        state_r;
   pack_state_e        state_s;
   logic [SHIFT_W-1:0] shift_r;
   logic [SHIFT_W-1:0] shift_s;
   logic               push_s;
   logic               pop_s;
   logic               drop_s;
   logic [WORD_W-1:0]  push_word_s;
   logic               overrun_r;

   assign word_valid  = ~fifo_empty;
   assign pop_s       = word_ready & word_valid;
   assign drop_s      = push_s & fifo_full & ~pop_s;
   assign push_word_s = {din, shift_r};
   assign overrun     = overrun_r;

   // Packer next-state: capture the byte into its lane; flush overrides a tick.
   always_comb begin
      state_s = state_r;
      shift_s = shift_r;
      push_s  = 1'b0;
      if (flush) begin
         state_s = B0;
         shift_s = '0;
      end else if (rx_done_tick) begin
         case (state_r)
            B0: begin
               shift_s[7:0] = din;
               state_s      = B1;
            end
            B1: begin
               shift_s[15:8] = din;
               state_s       = B2;
            end
            B2: begin
               shift_s[23:16] = din;
               state_s        = B3;
            end
            B3: begin
               push_s  = 1'b1;
               shift_s = '0;
               state_s = B0;
            end
            default: begin
               shift_s = '0;
               state_s = B0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Packer state and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= B0;
         shift_r <= '0;
      end else begin
         state_r <= state_s;
         shift_r <= shift_s;
      end
   end

   // Sticky overrun: a dropped word wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (overrun_clr) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .din   (push_word_s),
      .dout  (word_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
- Sits directly downstream of the UART receiver.
- Consumes received bytes (one byte per done tick) and packs them little-endian into 32-bit words.
- Buffers completed words in a small synchronous FIFO.
- Presents the words to the pipeline loader/debug unit over a valid/ready interface, with overrun detection and a flush for partially assembled words.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; fixed at 4 for a 32-bit word (other values unsupported).
- FIFO_DEPTH, 8, word entries in the FIFO; power of two, ≥2.
- PTR_W, 3, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle strobe from the receiver: din is valid this cycle.
- din  in  8  received byte.
- flush  in  1  synchronous; discards any partially packed word.
- word_ready  in  1  consumer accepts word_data this cycle.
- overrun_clr  in  1  synchronous clear of the overrun flag.
- word_valid  out  1  FIFO head holds a valid word.
- word_data  out  32  FIFO head word; byte0 is in [7:0].
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_empty  out  1  FIFO holds 0 words.
- count  out  PTR_W+1  number of words currently in the FIFO.
- overrun  out  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
Reset (rst_n=0, asynchronous):
- Packer state goes to B0; shift register clears to 0; pointers clear to 0.
- count=0, word_valid=0, fifo_empty=1, fifo_full=0, overrun=0, word_data=0.

Packer FSM, states B0, B1, B2, B3 (index of the next byte to capture):
- On rx_done_tick in Bk: din is written to shift_reg[8k+7:8k] and the state advances to Bk+1.
- In B3, the assembled word {din, shift_reg[23:0]} is pushed to the FIFO that same cycle and the state returns to B0.
- Latency: the fourth byte's tick produces word_valid=1 on the next rising edge (one cycle), when the FIFO was empty.
- flush=1 forces B0 next cycle and discards the partial bytes, even if rx_done_tick is high that cycle. A flush in B3 with a tick pushes nothing. The FIFO contents are unaffected.
- Bytes with no rx_done_tick are ignored; din is don't-care then.

FIFO:
- Registered storage array, write pointer, read pointer, and an occupancy counter of width PTR_W+1.
- word_data = mem[rd_ptr]; it is combinational from registered state (no extra read latency, first-word-fall-through).
- Pop occurs when word_valid & word_ready; rd_ptr increments and wraps modulo FIFO_DEPTH.
- Push occurs when the packer completes a word; wr_ptr increments and wraps modulo FIFO_DEPTH.
- Simultaneous push and pop when full: the pop frees a slot, so the push succeeds. count is unchanged and no overrun is flagged.
- Simultaneous push and pop when empty: the push succeeds. The pop is not qualified because word_valid=0. count goes 0→1.
- Push when full with no pop: the word is dropped, storage is unchanged, and overrun is set to 1 next cycle.
- word_ready while empty has no effect.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- fifo_full = (count==FIFO_DEPTH); fifo_empty = (count==0); word_valid = ~fifo_empty.

Overrun:
- Set on a dropped push.
- overrun_clr clears it, but a set in the same cycle wins over the clear.

Reset mid-word or mid-transfer:
- All state is lost immediately and asynchronously.
- The first byte after deassertion lands in byte0.

Decomposition:
- Shared package: BYTE_W=8, WORD_W=32, and an enum for the packer states B0–B3. This lets the receiver, transmitter and loader share them.
- Natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports clk, rst_n, push, pop, din, dout, full, empty, count).
- uart_rx_word_packer instantiates one sync_fifo with WIDTH=32 and wraps it with the packer FSM and overrun logic.

Test Plan:
1. Reset then bytes 0x11, 0x22, 0x33, 0x44 with word_ready=0 → one cycle after the 4th tick: word_valid=1, word_data=0x44332211, count=1.
2. Ten words (bytes 0x00..0x27) sent with word_ready=0, FIFO_DEPTH=8:
   - fifo_full=1 after word 8.
   - overrun=1 after word 9.
   - Draining yields 0x03020100 through 0x1F1E1D1C, in order, with no 9th/10th word.
   - Assert overrun_clr → overrun=0.
3. Bytes 0xAA, 0xBB, then flush, then 0x01, 0x02, 0x03, 0x04 → only word 0x04030201 appears; count=1.
4. FIFO full and word_ready=1 held while a 4th byte tick completes a word in the same cycle → count stays 8, overrun stays 0, and the new word emerges last on drain.
5. Continuous stream of 16 words with word_ready=1 every cycle → every word is delivered in order, count never exceeds 1, and the pointers wrap with no loss.
6. rst_n pulsed low after 2 bytes of a word and mid-drain → outputs go immediately to reset values; the next 4 bytes 0xDE, 0xAD, 0xBE, 0xEF give 0xEFBEADDE.
